// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path.
// Holds the hex glyph table (active-low, bit0 = a ... bit6 = g), the blank
// pattern, the segment bit positions, and the capture FSM state encoding.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
   localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
   localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
   localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
   localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
   localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
   localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
   localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
   localparam logic [6:0] SEG_HEX_A = 7'b0001000;
   localparam logic [6:0] SEG_HEX_B = 7'b0000011;
   localparam logic [6:0] SEG_HEX_C = 7'b1000110;
   localparam logic [6:0] SEG_HEX_D = 7'b0100001;
   localparam logic [6:0] SEG_HEX_E = 7'b0000110;
   localparam logic [6:0] SEG_HEX_F = 7'b0001110;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } cap_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment glyph decoder.
// Ports:
//   seg_n  - active-low segment pattern (bit0 = a ... bit6 = g)
//   known  - 1 when seg_n is one of the 16 hex glyphs
//   nibble - decoded hex value, 0 when the pattern is unknown
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic       known,
   output logic [3:0] nibble
);

   always_comb begin
      known  = 1'b1;
      nibble = 4'h0;
      case (seg_n)
         SEG_HEX_0: nibble = 4'h0;
         SEG_HEX_1: nibble = 4'h1;
         SEG_HEX_2: nibble = 4'h2;
         SEG_HEX_3: nibble = 4'h3;
         SEG_HEX_4: nibble = 4'h4;
         SEG_HEX_5: nibble = 4'h5;
         SEG_HEX_6: nibble = 4'h6;
         SEG_HEX_7: nibble = 4'h7;
         SEG_HEX_8: nibble = 4'h8;
         SEG_HEX_9: nibble = 4'h9;
         SEG_HEX_A: nibble = 4'ha;
         SEG_HEX_B: nibble = 4'hb;
         SEG_HEX_C: nibble = 4'hc;
         SEG_HEX_D: nibble = 4'hd;
         SEG_HEX_E: nibble = 4'he;
         SEG_HEX_F: nibble = 4'hf;
         default: begin
            known  = 1'b0;
            nibble = 4'h0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Recovers hex digits from a time-multiplexed active-low 7-segment bus.
// A digit is captured once its {seg_n, an_n} has been stable for STABLE_CYC
// samples; a full frame is published atomically once every digit is seen.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   seg_n       - active-low segment pattern
//   an_n        - active-low digit select, one bit per digit
//   cap_valid   - one-cycle pulse per captured digit, with cap_idx / cap_hex
//   err_pat     - with cap_valid when the captured pattern is not a glyph
//   value       - last complete frame, digit i at [4i+3:4i]
//   digit_ok    - per-digit known-glyph flags of the last frame
//   frame_done  - one-cycle pulse when value / digit_ok update
//   err_an      - one-cycle pulse when an_n first becomes multi-hot
//
// state  | meaning
// IDLE   | no digit selected (blank or multi-hot)
// SETTLE | one digit selected, counting identical samples
// HELD   | digit captured, waiting for the bus to change
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [6:0]                           seg_n,
   input  logic [NDIG-1:0]                      an_n,
   output logic                                 cap_valid,
   output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] cap_idx,
   output logic [3:0]                           cap_hex,
   output logic [4*NDIG-1:0]                    value,
   output logic [NDIG-1:0]                      digit_ok,
   output logic                                 frame_done,
   output logic                                 err_pat,
   output logic                                 err_an
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYC);

   cap_state_t           state;
   logic [CW-1:0]        cnt_q;
   logic [6+NDIG:0]      prev_q;
   logic                 mh_q;
   logic [NDIG-1:0]      mask_q;
   logic [4*NDIG-1:0]    shadow_q;
   logic [NDIG-1:0]      okshadow_q;

   logic [NDIG-1:0]      sel;
   logic                 sel_onehot;
   logic                 sel_multi;
   logic                 same;
   logic [IW-1:0]        idx;
   logic                 known;
   logic [3:0]           nib;
   logic                 start;
   logic                 cnt_inc;
   logic [CW-1:0]        cnt_nxt;
   logic                 capture;
   logic [NDIG-1:0]      mask_set;
   logic [4*NDIG-1:0]    shadow_upd;
   logic [NDIG-1:0]      ok_upd;

   seg7_to_hex u_dec (
      .seg_n  (seg_n),
      .known  (known),
      .nibble (nib)
   );

   assign sel        = ~an_n;
   assign sel_onehot = ($countones(sel) == 1);
   assign sel_multi  = ($countones(sel) > 1);
   assign same       = ({seg_n, an_n} == prev_q);

   always_comb begin
      idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (sel[i]) idx = IW'(i);
      end
   end

   // start: begin a fresh stability run; cnt_inc: extend the current run.
   // A fresh run may itself complete the count when STABLE_CYC is 1.
   always_comb begin
      start   = 1'b0;
      cnt_inc = 1'b0;
      case (state)
         IDLE:    start = sel_onehot;
         SETTLE:  begin
            if (same) cnt_inc = 1'b1;
            else      start   = sel_onehot;
         end
         HELD:    start = !same && sel_onehot;
         default: start = sel_onehot;
      endcase
      cnt_nxt = start ? CW'(1) : (cnt_q + CW'(1));
      capture = (start || cnt_inc) && (cnt_nxt == CNT_TC);
   end

   // Frame contents including the digit being captured this cycle.
   always_comb begin
      mask_set   = mask_q | (NDIG'(1) << idx);
      shadow_upd = shadow_q;
      shadow_upd[int'(idx)*4 +: 4] = nib;
      ok_upd     = okshadow_q;
      ok_upd[idx] = known;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt_q      <= '0;
         prev_q     <= '0;
         mh_q       <= 1'b0;
         mask_q     <= '0;
         shadow_q   <= '0;
         okshadow_q <= '0;
         cap_valid  <= 1'b0;
         cap_idx    <= '0;
         cap_hex    <= 4'h0;
         value      <= '0;
         digit_ok   <= '0;
         frame_done <= 1'b0;
         err_pat    <= 1'b0;
         err_an     <= 1'b0;
      end else begin
         prev_q     <= {seg_n, an_n};
         mh_q       <= sel_multi;
         err_an     <= sel_multi && !mh_q;
         cap_valid  <= capture;
         cap_idx    <= capture ? idx : '0;
         cap_hex    <= capture ? nib : 4'h0;
         err_pat    <= capture && !known;
         frame_done <= 1'b0;

         if (capture) begin
            state      <= HELD;
            cnt_q      <= cnt_nxt;
            shadow_q   <= shadow_upd;
            okshadow_q <= ok_upd;
            if (mask_set == {NDIG{1'b1}}) begin
               value      <= shadow_upd;
               digit_ok   <= ok_upd;
               frame_done <= 1'b1;
               mask_q     <= '0;
            end else begin
               mask_q <= mask_set;
            end
         end else if (start || cnt_inc) begin
            state <= SETTLE;
            cnt_q <= cnt_nxt;
         end else if (!(state == HELD && same)) begin
            state <= IDLE;
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

   localparam int NDIG = 4;
   localparam int S    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        cap_valid;
   logic [1:0]  cap_idx;
   logic [3:0]  cap_hex;
   logic [15:0] value;
   logic [3:0]  digit_ok;
   logic        frame_done;
   logic        err_pat;
   logic        err_an;

   seg7_capture #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .cap_valid  (cap_valid),
      .cap_idx    (cap_idx),
      .cap_hex    (cap_hex),
      .value      (value),
      .digit_ok   (digit_ok),
      .frame_done (frame_done),
      .err_pat    (err_pat),
      .err_an     (err_an)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] glyph [16];

   // reference model: run length of identical one-hot samples
   int         m_run;
   logic [10:0] m_prev;
   bit         m_mh_prev;
   logic [3:0] m_sh [4];
   bit         m_oksh [4];
   bit         m_got [4];
   logic        e_cap_valid, e_frame_done, e_err_pat, e_err_an;
   logic [1:0]  e_cap_idx;
   logic [3:0]  e_cap_hex;
   logic [15:0] e_value;
   logic [3:0]  e_ok;

   // observation counters for directed sequences
   int         cyc = 0;
   int         n_cap = 0, n_frame = 0, n_err_an = 0;
   int         last_cap_cyc = 0;
   logic [3:0] last_hex;
   logic       last_errpat;
   logic [3:0] caplog [$];

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
      logic [3:0] hex;
      logic       bad;
   } vec_t;
   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_prev = '0; m_mh_prev = 0;
      for (int i = 0; i < 4; i++) begin
         m_sh[i] = 4'h0; m_oksh[i] = 0; m_got[i] = 0;
      end
      e_cap_valid = 0; e_frame_done = 0; e_err_pat = 0; e_err_an = 0;
      e_cap_idx = 0; e_cap_hex = 0; e_value = 0; e_ok = 0;
   endtask

   task automatic model_edge(input logic [6:0] s, input logic [3:0] a);
      int  nl;
      bit  oh, mh, kn, all;
      int  hx, ix;
      nl = $countones(~a);
      oh = (nl == 1);
      mh = (nl >= 2);
      e_err_an = mh && !m_mh_prev;
      m_mh_prev = mh;
      e_cap_valid = 0; e_cap_idx = 0; e_cap_hex = 0; e_err_pat = 0; e_frame_done = 0;
      if (oh) begin
         if (m_run > 0 && {s, a} == m_prev) m_run++;
         else m_run = 1;
      end else begin
         m_run = 0;
      end
      m_prev = {s, a};
      if (oh && m_run == S) begin
         ix = 0;
         for (int i = 0; i < 4; i++) if (a[i] == 1'b0) ix = i;
         kn = 0; hx = 0;
         for (int g = 0; g < 16; g++) if (glyph[g] == s) begin kn = 1; hx = g; end
         e_cap_valid = 1; e_cap_idx = 2'(ix); e_cap_hex = 4'(hx); e_err_pat = !kn;
         m_sh[ix] = 4'(hx); m_oksh[ix] = kn; m_got[ix] = 1;
         all = 1;
         for (int i = 0; i < 4; i++) if (!m_got[i]) all = 0;
         if (all) begin
            for (int i = 0; i < 4; i++) begin
               e_value[4*i +: 4] = m_sh[i];
               e_ok[i] = m_oksh[i];
               m_got[i] = 0;
            end
            e_frame_done = 1;
         end
      end
   endtask

   task automatic compare_all();
      chk("cap_valid", cap_valid, e_cap_valid);
      chk("cap_idx", cap_idx, e_cap_idx);
      chk("cap_hex", cap_hex, e_cap_hex);
      chk("err_pat", err_pat, e_err_pat);
      chk("err_an", err_an, e_err_an);
      chk("frame_done", frame_done, e_frame_done);
      chk("value", value, e_value);
      chk("digit_ok", digit_ok, e_ok);
   endtask

   task automatic step(input logic [6:0] s, input logic [3:0] a);
      seg_n = s;
      an_n  = a;
      @(posedge clk);
      model_edge(s, a);
      #1;
      cyc++;
      compare_all();
      if (cap_valid) begin
         n_cap++; last_hex = cap_hex; last_errpat = err_pat;
         last_cap_cyc = cyc; caplog.push_back(cap_hex);
      end
      if (frame_done) n_frame++;
      if (err_an) n_err_an++;
   endtask

   task automatic hold(input int g, input int d, input int n);
      repeat (n) step(glyph[g], ~(4'b0001 << d));
   endtask

   task automatic do_reset();
      rst = 1'b1; seg_n = 7'h7f; an_n = 4'hf;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int n0, f0, a0, h0;
      logic [6:0] pats [4];
      glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      for (int i = 0; i < 16; i++)
         vecs[i] = '{glyph[i], ~(4'b0001 << (i % 4)), 4'(i), 1'b0};
      vecs[16] = '{7'b1111111, 4'b1101, 4'h0, 1'b1};
      vecs[17] = '{7'b0101010, 4'b0111, 4'h0, 1'b1};

      do_reset();

      // glyph table, one vector per record
      for (int v = 0; v < 18; v++) begin
         n0 = n_cap;
         repeat (5) step(vecs[v].seg, vecs[v].an);
         step(7'h7f, 4'hf);
         chk("tbl_ncap", n_cap - n0, 1);
         chk("tbl_hex", last_hex, vecs[v].hex);
         chk("tbl_errpat", last_errpat, vecs[v].bad);
      end

      // basic frame
      do_reset();
      caplog.delete();
      f0 = n_frame;
      pats = '{7'b0000010, 7'b1111001, 7'b0001110, 7'b1000000};
      for (int d = 0; d < 4; d++) repeat (6) step(pats[d], ~(4'b0001 << d));
      chk("frame_ncap", caplog.size(), 4);
      if (caplog.size() == 4) begin
         chk("frame_hex0", caplog[0], 4'h6);
         chk("frame_hex1", caplog[1], 4'h1);
         chk("frame_hex2", caplog[2], 4'hf);
         chk("frame_hex3", caplog[3], 4'h0);
      end
      chk("frame_count", n_frame - f0, 1);
      chk("frame_value", value, 16'h0f16);
      chk("frame_ok", digit_ok, 4'hf);

      // glitching digit 2, then a stable 7
      do_reset();
      n0 = n_cap;
      for (int k = 0; k < 10; k++)
         step(((k / 2) % 2) != 0 ? 7'b0000000 : 7'b1111001, 4'b1011);
      h0 = cyc;
      repeat (6) step(7'b1111000, 4'b1011);
      chk("glitch_ncap", n_cap - n0, 1);
      chk("glitch_hex", last_hex, 4'h7);
      chk("glitch_lat", last_cap_cyc - h0, S);

      // unknown glyph on digit 0
      do_reset();
      n0 = n_cap; f0 = n_frame;
      repeat (5) step(7'b1111111, 4'b1110);
      chk("unk_ncap", n_cap - n0, 1);
      chk("unk_errpat", last_errpat, 1);
      chk("unk_hex", last_hex, 4'h0);
      for (int d = 1; d < 4; d++) hold(d, d, 6);
      chk("unk_frame", n_frame - f0, 1);
      chk("unk_ok", digit_ok, 4'b1110);
      chk("unk_value", value, 16'h3210);

      // multi-hot select mid-frame
      do_reset();
      hold(5, 0, 6);
      n0 = n_cap; a0 = n_err_an; f0 = n_frame;
      repeat (3) step(glyph[8], 4'b1100);
      step(7'h7f, 4'hf);
      chk("mh_err_an", n_err_an - a0, 1);
      chk("mh_ncap", n_cap - n0, 0);
      chk("mh_value", value, 16'h0);
      for (int d = 1; d < 4; d++) hold(d, d, 6);
      chk("mh_frame", n_frame - f0, 1);
      chk("mh_value2", value, 16'h3215);

      // re-capture of digit 1 before frame completes
      do_reset();
      f0 = n_frame;
      hold(3, 1, 6);
      hold(9, 1, 6);
      hold(10, 0, 6);
      hold(11, 2, 6);
      hold(12, 3, 6);
      chk("recap_frame", n_frame - f0, 1);
      chk("recap_value", value, 16'hcb9a);

      // async reset mid-frame
      do_reset();
      for (int d = 0; d < 4; d++) hold(4 - d, d, 6);
      chk("rst_pre_value", value, 16'h1234);
      for (int d = 0; d < 3; d++) hold(7, d, 6);
      #2;
      rst = 1'b1; seg_n = 7'h7f; an_n = 4'hf;
      model_reset();
      #1;
      compare_all();
      chk("rst_async_value", value, 16'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      f0 = n_frame;
      for (int d = 0; d < 3; d++) hold(8 + d, d, 6);
      chk("rst_partial_frame", n_frame - f0, 0);
      chk("rst_partial_value", value, 16'h0);
      hold(11, 3, 6);
      chk("rst_new_frame", n_frame - f0, 1);
      chk("rst_new_value", value, 16'hba98);

      // randomized traffic against the model
      do_reset();
      for (int r = 0; r < 150; r++) begin
         logic [6:0] s;
         logic [3:0] a;
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 7)      a = ~(4'b0001 << $urandom_range(0, 3));
         else if (kind == 7) a = 4'hf;
         else               a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) != 0) s = glyph[$urandom_range(0, 15)];
         else                           s = 7'($urandom_range(0, 127));
         repeat ($urandom_range(1, 7)) step(s, a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
